jk_excitation_driver: RTL and testbench

Drives a bank of JK flip-flops toward requested target states. For each accepted target vector it derives J/K excitation from the flops' present state and drives it for exactly one clock. It then reads the flops back and reports per-bit mismatches. It is the stimulus side of the JK flip-flop interface: it produces the j/k inputs and consumes q.

---
 rtl/jk_drv_pkg.sv | 25 ++
 rtl/jk_excite.sv | 26 ++
 rtl/jk_excitation_driver.sv | 114 +++++++++++
 tb/tb_jk_excitation_driver.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_drv_pkg.sv
// Shared types and the per-bit JK excitation table for the JK bank driver.
// Pure declarations; no clocked state.
package jk_drv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic DC_ZERO = 1'b0;
    localparam logic DC_ONE  = 1'b1;

    // Returns {j,k} moving one flop from present to nxt; dc fills the don't-care input.
    function automatic logic [1:0] excite(input logic present, input logic nxt, input logic dc);
        logic [1:0] jk;
        if (present) begin
            jk = {dc, ~nxt};
        end else begin
            jk = {nxt, dc};
        end
        return jk;
    endfunction

endpackage

// File: rtl/jk_excite.sv
// Purpose: maps requested next state and present bank state to J/K excitation.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module jk_excite
    import jk_drv_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int DC_POLICY = 0
) (
    input  logic [WIDTH-1:0] tgt_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j_nxt,
    output logic [WIDTH-1:0] k_nxt
);

    localparam logic DC_BIT = (DC_POLICY != 0) ? DC_ONE : DC_ZERO;

    always_comb begin
        j_nxt = '0;
        k_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            {j_nxt[i], k_nxt[i]} = excite(q_fb[i], tgt_data[i], DC_BIT);
        end
    end

endmodule

// File: rtl/jk_excitation_driver.sv
// Purpose: drives a JK bank toward accepted targets, then checks q_fb and counts failures.
// Latency: j/k one cycle after accept, done/err two cycles after accept; one target per 3 cycles.
// Backpressure: tgt_ready is high only in IDLE; tgt_valid elsewhere is ignored.
module jk_excitation_driver
    import jk_drv_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int DC_POLICY = 0,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] q_fb,
    input  logic             cnt_clr,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_bits,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] tgt_q;
    logic [WIDTH-1:0] j_exc;
    logic [WIDTH-1:0] k_exc;
    logic [WIDTH-1:0] j_d;
    logic [WIDTH-1:0] k_d;
    logic [WIDTH-1:0] diff;
    logic             accept;
    logic             check_now;

    jk_excite #(
        .WIDTH     (WIDTH),
        .DC_POLICY (DC_POLICY)
    ) u_excite (
        .tgt_data (tgt_data),
        .q_fb     (q_fb),
        .j_nxt    (j_exc),
        .k_nxt    (k_exc)
    );

    assign diff      = q_fb ^ tgt_q;
    assign tgt_ready = (state == IDLE);
    assign busy      = (state == DRIVE) || (state == CHECK);

    // j/k are non-zero only for the single cycle following an accept.
    always_comb begin
        state_nxt = state;
        j_d       = '0;
        k_d       = '0;
        accept    = 1'b0;
        check_now = 1'b0;
        case (state)
            IDLE: begin
                if (tgt_valid) begin
                    accept    = 1'b1;
                    j_d       = j_exc;
                    k_d       = k_exc;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                state_nxt = CHECK;
            end
            CHECK: begin
                check_now = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            j        <= '0;
            k        <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_bits <= '0;
            err_cnt  <= '0;
            tgt_q    <= '0;
        end else begin
            state <= state_nxt;
            j     <= j_d;
            k     <= k_d;
            done  <= check_now;
            err   <= check_now && (|diff);
            if (accept) begin
                tgt_q <= tgt_data;
            end
            if (check_now) begin
                err_bits <= diff;
            end
            // Clear wins over a coincident increment.
            if (cnt_clr) begin
                err_cnt <= '0;
            end else if (check_now && (|diff) && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench: two drivers (DC_POLICY 0 and 1) share stimulus, each driving its own JK bank.
module tb_jk_excitation_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tgt_valid;
    logic [3:0] tgt_data;
    logic       cnt_clr;

    logic       rdy0, rdy1, busy0, busy1, done0, done1, err0, err1;
    logic [3:0] j0, k0, j1, k1, eb0, eb1;
    logic [7:0] cnt0, cnt1;

    logic [3:0] bank0, bank1, q0, q1, stuck, load_val;
    logic       load_en;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign q0 = bank0 & ~stuck;
    assign q1 = bank1 & ~stuck;

    jk_excitation_driver #(.WIDTH(4), .DC_POLICY(0), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_ready(rdy0),
        .tgt_data(tgt_data), .j(j0), .k(k0), .q_fb(q0), .cnt_clr(cnt_clr),
        .busy(busy0), .done(done0), .err(err0), .err_bits(eb0), .err_cnt(cnt0)
    );

    jk_excitation_driver #(.WIDTH(4), .DC_POLICY(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_ready(rdy1),
        .tgt_data(tgt_data), .j(j1), .k(k1), .q_fb(q1), .cnt_clr(cnt_clr),
        .busy(busy1), .done(done1), .err(err1), .err_bits(eb1), .err_cnt(cnt1)
    );

    // Behavioural JK bank: Q+ = J&~Q | ~K&Q, with a bench-side preload.
    always @(posedge clk) begin
        if (load_en) begin
            bank0 <= load_val;
            bank1 <= load_val;
        end else begin
            bank0 <= (j0 & ~bank0) | (~k0 & bank0);
            bank1 <= (j1 & ~bank1) | (~k1 & bank1);
        end
    end

    // Handshake monitor for dut0.
    int         cyc = 0;
    int         acc_n = 0;
    int         acc_cyc [16];
    logic [3:0] acc_dat [16];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n === 1'b1 && tgt_valid === 1'b1 && rdy0 === 1'b1) begin
            if (acc_n < 16) begin
                acc_cyc[acc_n] <= cyc;
                acc_dat[acc_n] <= tgt_data;
            end
            acc_n <= acc_n + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_bank(input logic [3:0] v);
        @(negedge clk);
        load_en  = 1'b1;
        load_val = v;
        @(posedge clk);
        #1 load_en = 1'b0;
    endtask

    task automatic wait_ready();
        int t = 0;
        @(negedge clk);
        while (rdy0 !== 1'b1 && t < 8) begin
            @(negedge clk);
            t++;
        end
        if (rdy0 !== 1'b1) check_val("ready_timeout", {31'd0, rdy0}, 32'd1);
    endtask

    logic [3:0] obs_j0, obs_k0, obs_j1, obs_k1;

    // Returns at the negedge of the cycle where done should be high.
    task automatic send(input logic [3:0] d);
        wait_ready();
        tgt_valid = 1'b1;
        tgt_data  = d;
        @(posedge clk);
        #1 tgt_valid = 1'b0;
        @(negedge clk);
        obs_j0 = j0; obs_k0 = k0; obs_j1 = j1; obs_k1 = k1;
        @(negedge clk);
        @(negedge clk);
    endtask

    logic [3:0] hs [6];
    int         base;
    int         seen;

    initial begin
        rst_n     = 1'b0;
        tgt_valid = 1'b1;
        tgt_data  = 4'b1010;
        cnt_clr   = 1'b0;
        load_en   = 1'b0;
        load_val  = 4'b0000;
        stuck     = 4'b0000;

        // Reset with tgt_valid held high
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_ready", {31'd0, rdy0}, 32'd1);
        check_val("rst_busy",  {31'd0, busy0}, 32'd0);
        check_val("rst_j",     {28'd0, j0}, 32'd0);
        check_val("rst_k",     {28'd0, k0}, 32'd0);
        check_val("rst_done",  {31'd0, done0}, 32'd0);
        check_val("rst_cnt",   {24'd0, cnt0}, 32'd0);
        check_val("rst_jk1",   {24'd0, j1, k1}, 32'd0);
        tgt_valid = 1'b0;
        rst_n     = 1'b1;
        repeat (2) @(negedge clk);
        check_val("rst_no_capture", acc_n, 32'd0);
        check_val("rst_idle_busy",  {31'd0, busy0}, 32'd0);
        check_val("rst_err_bits",   {28'd0, eb0}, 32'd0);

        // Excitation 0101 -> 0011
        load_bank(4'b0101);
        send(4'b0011);
        check_val("dc0_j", {28'd0, obs_j0}, 32'b0010);
        check_val("dc0_k", {28'd0, obs_k0}, 32'b0100);
        check_val("dc1_j", {28'd0, obs_j1}, 32'b0111);
        check_val("dc1_k", {28'd0, obs_k1}, 32'b1110);
        check_val("ex1_done0", {31'd0, done0}, 32'd1);
        check_val("ex1_err0",  {31'd0, err0}, 32'd0);
        check_val("ex1_eb0",   {28'd0, eb0}, 32'd0);
        check_val("ex1_bank0", {28'd0, bank0}, 32'b0011);
        check_val("ex1_bank1", {28'd0, bank1}, 32'b0011);
        check_val("ex1_err1",  {31'd0, err1}, 32'd0);
        check_val("ex1_ready", {31'd0, rdy0}, 32'd1);
        @(negedge clk);
        check_val("ex1_done_pulse", {31'd0, done0}, 32'd0);

        // Every bit flips: 1001 -> 0110
        load_bank(4'b1001);
        send(4'b0110);
        check_val("ex2_j0", {28'd0, obs_j0}, 32'b0110);
        check_val("ex2_k0", {28'd0, obs_k0}, 32'b1001);
        check_val("ex2_j1", {28'd0, obs_j1}, 32'b1111);
        check_val("ex2_k1", {28'd0, obs_k1}, 32'b1111);
        check_val("ex2_bank0", {28'd0, bank0}, 32'b0110);
        check_val("ex2_bank1", {28'd0, bank1}, 32'b0110);
        check_val("ex2_done1", {31'd0, done1}, 32'd1);

        // tgt_valid held 6 edges with data changing every edge
        hs[0] = 4'h1; hs[1] = 4'h2; hs[2] = 4'h3;
        hs[3] = 4'h9; hs[4] = 4'h5; hs[5] = 4'h6;
        wait_ready();
        base      = acc_n;
        tgt_valid = 1'b1;
        tgt_data  = hs[0];
        for (int e = 0; e < 6; e++) begin
            @(posedge clk);
            #1;
            if (e < 5) tgt_data = hs[e+1];
        end
        tgt_valid = 1'b0;
        @(negedge clk);
        check_val("hs_count", acc_n - base, 32'd2);
        check_val("hs_spacing", acc_cyc[base+1] - acc_cyc[base], 32'd3);
        check_val("hs_first_dat",  {28'd0, acc_dat[base]}, 32'h1);
        check_val("hs_second_dat", {28'd0, acc_dat[base+1]}, 32'h9);
        check_val("hs_done", {31'd0, done0}, 32'd1);
        check_val("hs_bank0", {28'd0, bank0}, 32'h9);
        check_val("hs_bank1", {28'd0, bank1}, 32'h9);

        // Bit 2 of q_fb stuck at 0
        stuck = 4'b0100;
        load_bank(4'b0000);
        send(4'b1111);
        check_val("flt_err0", {31'd0, err0}, 32'd1);
        check_val("flt_eb0",  {28'd0, eb0}, 32'b0100);
        check_val("flt_cnt0", {24'd0, cnt0}, 32'd1);
        check_val("flt_eb1",  {28'd0, eb1}, 32'b0100);
        check_val("flt_cnt1", {24'd0, cnt1}, 32'd1);
        for (int n = 0; n < 254; n++) send(4'b1111);
        check_val("flt_cnt_255", {24'd0, cnt0}, 32'd255);
        send(4'b1111);
        check_val("flt_sat0", {24'd0, cnt0}, 32'd255);
        check_val("flt_sat1", {24'd0, cnt1}, 32'd255);
        check_val("flt_sat_err", {31'd0, err0}, 32'd1);

        // Reset asserted during DRIVE
        load_bank(4'b0000);
        wait_ready();
        tgt_valid = 1'b1;
        tgt_data  = 4'b1111;
        @(posedge clk);
        #1 tgt_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_val("mid_drive_j0", {28'd0, j0}, 32'b1111);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("mid_jk0",   {24'd0, j0, k0}, 32'd0);
        check_val("mid_jk1",   {24'd0, j1, k1}, 32'd0);
        check_val("mid_ready", {31'd0, rdy0}, 32'd1);
        check_val("mid_busy",  {31'd0, busy0}, 32'd0);
        seen = 0;
        for (int n = 0; n < 3; n++) begin
            if (done0 !== 1'b0 || done1 !== 1'b0 || err0 !== 1'b0) seen = 1;
            @(negedge clk);
        end
        check_val("mid_no_done", seen, 32'd0);
        check_val("mid_bank0", {28'd0, bank0}, 32'b1111);
        check_val("mid_bank1", {28'd0, bank1}, 32'b1111);
        check_val("mid_cnt_clr", {24'd0, cnt0}, 32'd0);

        // cnt_clr coinciding with a failing check
        send(4'b1111);
        check_val("clr_pre_cnt", {24'd0, cnt0}, 32'd1);
        cnt_clr = 1'b1;
        send(4'b1111);
        check_val("clr_err",  {31'd0, err0}, 32'd1);
        check_val("clr_cnt0", {24'd0, cnt0}, 32'd0);
        check_val("clr_cnt1", {24'd0, cnt1}, 32'd0);
        cnt_clr = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
